// File: rtl/reorder_buffer.sv
// 8-entry circular reorder buffer: in-order allocate at tail, out-of-order CDB
// writeback by tag, in-order retire from head with a combinational operand lookup.
module reorder_buffer #(
  parameter int DEPTH  = 8,
  parameter int TAG_W  = 3,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              alloc_valid,
  input  logic [3:0]        alloc_opcode,
  input  logic [3:0]        alloc_dest,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_value,
  input  logic [TAG_W-1:0]  rd_tag,
  output logic              rd_ready,
  output logic [DATA_W-1:0] rd_value,
  output logic              commit_valid,
  output logic [3:0]        commit_opcode,
  output logic [3:0]        commit_dest,
  output logic [DATA_W-1:0] commit_value,
  output logic [TAG_W-1:0]  commit_tag,
  output logic              full,
  output logic              empty
);

  logic [DEPTH-1:0]  busy_reg;
  logic [DEPTH-1:0]  done_reg;
  logic [3:0]        opcode_reg [DEPTH];
  logic [3:0]        dest_reg   [DEPTH];
  logic [DATA_W-1:0] value_reg  [DEPTH];
  logic [TAG_W-1:0]  head_reg;
  logic [TAG_W-1:0]  tail_reg;
  logic [TAG_W:0]    count_reg;
  logic [TAG_W:0]    count_next;

  logic              alloc_fire;
  logic              commit_fire;
  logic              bypass;
  logic [DEPTH-1:0]  alloc_hit;
  logic [DEPTH-1:0]  commit_hit;
  logic [DEPTH-1:0]  wb_hit;

  assign full        = (count_reg == (TAG_W+1)'(DEPTH));
  assign empty       = (count_reg == '0);
  assign alloc_ready = !full;
  assign alloc_tag   = tail_reg;

  // Acceptance is judged on pre-edge state, so a full buffer refuses even while retiring.
  assign alloc_fire  = alloc_valid && !full;
  assign commit_fire = busy_reg[head_reg] && done_reg[head_reg];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry_ctl
      assign alloc_hit[gi]  = alloc_fire && (tail_reg == TAG_W'(gi));
      assign commit_hit[gi] = commit_fire && (head_reg == TAG_W'(gi));
      assign wb_hit[gi]     = cdb_valid && (cdb_tag == TAG_W'(gi)) &&
                              busy_reg[gi] && !done_reg[gi];
    end
  endgenerate

  // Alloc only hits a free entry, commit only a done one, writeback only a busy
  // not-done one, so the three never target the same entry together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_reg <= '0;
      done_reg <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        opcode_reg[i] <= '0;
        dest_reg[i]   <= '0;
        value_reg[i]  <= '0;
      end
    end else if (flush) begin
      busy_reg <= '0;
      done_reg <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc_hit[i]) begin
          busy_reg[i]   <= 1'b1;
          done_reg[i]   <= 1'b0;
          opcode_reg[i] <= alloc_opcode;
          dest_reg[i]   <= alloc_dest;
          value_reg[i]  <= '0;
        end else if (commit_hit[i]) begin
          busy_reg[i] <= 1'b0;
          done_reg[i] <= 1'b0;
        end else if (wb_hit[i]) begin
          done_reg[i]  <= 1'b1;
          value_reg[i] <= cdb_value;
        end
      end
    end
  end

  assign count_next = count_reg + (TAG_W+1)'(alloc_fire) - (TAG_W+1)'(commit_fire);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (flush) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (alloc_fire)  tail_reg <= tail_reg + 1'b1;
      if (commit_fire) head_reg <= head_reg + 1'b1;
      count_reg <= count_next;
    end
  end

  // Commit fields hold their last retired values between pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      commit_valid  <= 1'b0;
      commit_opcode <= '0;
      commit_dest   <= '0;
      commit_value  <= '0;
      commit_tag    <= '0;
    end else if (flush) begin
      commit_valid <= 1'b0;
    end else begin
      commit_valid <= commit_fire;
      if (commit_fire) begin
        commit_opcode <= opcode_reg[head_reg];
        commit_dest   <= dest_reg[head_reg];
        commit_value  <= value_reg[head_reg];
        commit_tag    <= head_reg;
      end
    end
  end

  always_comb begin
    bypass   = cdb_valid && (cdb_tag == rd_tag) && busy_reg[rd_tag];
    rd_ready = (busy_reg[rd_tag] && done_reg[rd_tag]) || bypass;
    rd_value = '0;
    if (bypass)
      rd_value = cdb_value;
    else if (busy_reg[rd_tag])
      rd_value = value_reg[rd_tag];
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer: alloc, writeback, in-order
// commit, full/wrap, operand bypass, flush and asynchronous reset.
module tb_reorder_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       alloc_valid;
  logic [3:0] alloc_opcode;
  logic [3:0] alloc_dest;
  logic       alloc_ready;
  logic [2:0] alloc_tag;
  logic       cdb_valid;
  logic [2:0] cdb_tag;
  logic [7:0] cdb_value;
  logic [2:0] rd_tag;
  logic       rd_ready;
  logic [7:0] rd_value;
  logic       commit_valid;
  logic [3:0] commit_opcode;
  logic [3:0] commit_dest;
  logic [7:0] commit_value;
  logic [2:0] commit_tag;
  logic       full;
  logic       empty;

  int total = 0;
  int bad   = 0;

  reorder_buffer #(.DEPTH(8), .TAG_W(3), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_opcode(alloc_opcode), .alloc_dest(alloc_dest),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .rd_tag(rd_tag), .rd_ready(rd_ready), .rd_value(rd_value),
    .commit_valid(commit_valid), .commit_opcode(commit_opcode), .commit_dest(commit_dest),
    .commit_value(commit_value), .commit_tag(commit_tag),
    .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; alloc_valid = 1'b0; alloc_opcode = '0; alloc_dest = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0; rd_tag = '0;
    #2;
    total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL reset_commit_valid got=%0h exp=0", commit_valid); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%0h exp=1", empty); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%0h exp=0", full); end
    total++; if (alloc_ready !== 1'b1) begin bad++; $display("FAIL reset_alloc_ready got=%0h exp=1", alloc_ready); end
    total++; if (alloc_tag !== 3'd0) begin bad++; $display("FAIL reset_alloc_tag got=%0h exp=0", alloc_tag); end
    total++; if (commit_dest !== 4'd0 || commit_value !== 8'd0) begin bad++; $display("FAIL reset_commit_fields got=%0h/%0h exp=0/0", commit_dest, commit_value); end
    tick();
    rst = 1'b0;
    $display("test_reset: checked");
  endtask

  task automatic test_alloc();
    logic [3:0] d;
    for (int i = 0; i < 3; i++) begin
      d = 4'(i + 2);
      alloc_valid = 1'b1; alloc_opcode = 4'b0001; alloc_dest = d;
      #1;
      total++; if (alloc_tag !== 3'(i)) begin bad++; $display("FAIL alloc_tag_%0d got=%0h exp=%0h", i, alloc_tag, i); end
      tick();
      $display("alloc dest=%0d", d);
    end
    alloc_valid = 1'b0;
    total++; if (alloc_tag !== 3'd3) begin bad++; $display("FAIL alloc_tail got=%0h exp=3", alloc_tag); end
    total++; if (empty !== 1'b0) begin bad++; $display("FAIL alloc_empty got=%0h exp=0", empty); end
    total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL alloc_no_commit got=%0h exp=0", commit_valid); end
  endtask

  task automatic test_writeback_order();
    cdb_valid = 1'b1; cdb_tag = 3'd1; cdb_value = 8'h11;
    tick();
    cdb_valid = 1'b0;
    total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL wb1_no_commit got=%0h exp=0", commit_valid); end
    rd_tag = 3'd1; #1;
    total++; if (rd_ready !== 1'b1 || rd_value !== 8'h11) begin bad++; $display("FAIL lookup_tag1 got=%0h/%0h exp=1/11", rd_ready, rd_value); end
    cdb_valid = 1'b1; cdb_tag = 3'd0; cdb_value = 8'h22;
    tick();
    cdb_valid = 1'b0;
    total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL wb0_latency got=%0h exp=0", commit_valid); end
    tick();
    $display("commit tag=%0d dest=%0d value=%0h", commit_tag, commit_dest, commit_value);
    total++; if ({commit_valid, commit_tag, commit_dest, commit_value, commit_opcode} !== {1'b1, 3'd0, 4'd2, 8'h22, 4'd1}) begin
      bad++; $display("FAIL commit0 got=%0h/%0h/%0h/%0h exp=1/0/2/22", commit_valid, commit_tag, commit_dest, commit_value); end
    tick();
    $display("commit tag=%0d dest=%0d value=%0h", commit_tag, commit_dest, commit_value);
    total++; if ({commit_valid, commit_tag, commit_dest, commit_value} !== {1'b1, 3'd1, 4'd3, 8'h11}) begin
      bad++; $display("FAIL commit1 got=%0h/%0h/%0h/%0h exp=1/1/3/11", commit_valid, commit_tag, commit_dest, commit_value); end
    tick();
    total++; if (commit_valid !== 1'b0 || commit_dest !== 4'd3) begin bad++; $display("FAIL commit_hold got=%0h/%0h exp=0/3", commit_valid, commit_dest); end
  endtask

  task automatic test_bypass();
    rd_tag = 3'd2; #1;
    total++; if (rd_ready !== 1'b0) begin bad++; $display("FAIL lookup_pending got=%0h exp=0", rd_ready); end
    cdb_valid = 1'b1; cdb_tag = 3'd2; cdb_value = 8'h5A; #1;
    total++; if (rd_ready !== 1'b1 || rd_value !== 8'h5A) begin bad++; $display("FAIL bypass got=%0h/%0h exp=1/5a", rd_ready, rd_value); end
    tick();
    cdb_valid = 1'b0;
    tick();
    total++; if ({commit_valid, commit_tag, commit_dest, commit_value} !== {1'b1, 3'd2, 4'd4, 8'h5A}) begin
      bad++; $display("FAIL commit2 got=%0h/%0h/%0h/%0h exp=1/2/4/5a", commit_valid, commit_tag, commit_dest, commit_value); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL drained_empty got=%0h exp=1", empty); end
    cdb_valid = 1'b1; cdb_tag = 3'd6; cdb_value = 8'h77; rd_tag = 3'd6; #1;
    total++; if (rd_ready !== 1'b0 || rd_value !== 8'h00) begin bad++; $display("FAIL nonbusy_lookup got=%0h/%0h exp=0/0", rd_ready, rd_value); end
    tick();
    cdb_valid = 1'b0; #1;
    total++; if (rd_ready !== 1'b0 || empty !== 1'b1 || commit_valid !== 1'b0) begin
      bad++; $display("FAIL nonbusy_wb got=%0h/%0h/%0h exp=0/1/0", rd_ready, empty, commit_valid); end
  endtask

  task automatic test_full_wrap();
    logic [7:0] ev;
    logic [3:0] ed;
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      alloc_valid = 1'b1; alloc_opcode = 4'(i); alloc_dest = 4'(i + 8); #1;
      total++; if (alloc_tag !== 3'(i)) begin bad++; $display("FAIL fill_tag_%0d got=%0h exp=%0h", i, alloc_tag, i); end
      tick();
    end
    total++; if (full !== 1'b1 || alloc_ready !== 1'b0) begin bad++; $display("FAIL full got=%0h/%0h exp=1/0", full, alloc_ready); end
    alloc_dest = 4'd15;
    tick();
    alloc_valid = 1'b0;
    total++; if (full !== 1'b1 || alloc_tag !== 3'd0) begin bad++; $display("FAIL drop9 got=%0h/%0h exp=1/0", full, alloc_tag); end
    for (int i = 0; i < 8; i++) begin
      cdb_valid = 1'b1; cdb_tag = 3'(i); cdb_value = 8'(8'h80 + i);
      tick();
      if (i == 0) begin
        total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL fill_first_latency got=%0h exp=0", commit_valid); end
      end else begin
        ev = 8'(8'h80 + i - 1); ed = 4'(i + 7);
        $display("commit tag=%0d dest=%0d value=%0h", commit_tag, commit_dest, commit_value);
        total++; if ({commit_valid, commit_tag, commit_dest, commit_value} !== {1'b1, 3'(i - 1), ed, ev}) begin
          bad++; $display("FAIL drain_%0d got=%0h/%0h/%0h/%0h exp=1/%0h/%0h/%0h", i - 1, commit_valid, commit_tag, commit_dest, commit_value, i - 1, ed, ev); end
      end
    end
    cdb_valid = 1'b0;
    tick();
    total++; if ({commit_valid, commit_tag, commit_dest, commit_value} !== {1'b1, 3'd7, 4'd15, 8'h87}) begin
      bad++; $display("FAIL drain_7 got=%0h/%0h/%0h/%0h exp=1/7/f/87", commit_valid, commit_tag, commit_dest, commit_value); end
    tick();
    total++; if (commit_valid !== 1'b0 || empty !== 1'b1 || alloc_tag !== 3'd0) begin
      bad++; $display("FAIL wrap_idle got=%0h/%0h/%0h exp=0/1/0", commit_valid, empty, alloc_tag); end
  endtask

  task automatic test_full_commit_alloc();
    for (int i = 0; i < 8; i++) begin
      alloc_valid = 1'b1; alloc_opcode = 4'b0100; alloc_dest = 4'(i == 0 ? 5 : 1);
      tick();
    end
    alloc_valid = 1'b0;
    cdb_valid = 1'b1; cdb_tag = 3'd0; cdb_value = 8'h44;
    tick();
    cdb_valid = 1'b0;
    alloc_valid = 1'b1; alloc_dest = 4'd9;
    tick();
    total++; if ({commit_valid, commit_tag, commit_dest, commit_value, commit_opcode} !== {1'b1, 3'd0, 4'd5, 8'h44, 4'b0100}) begin
      bad++; $display("FAIL full_commit got=%0h/%0h/%0h/%0h exp=1/0/5/44", commit_valid, commit_tag, commit_dest, commit_value); end
    total++; if (full !== 1'b0 || alloc_tag !== 3'd0) begin bad++; $display("FAIL full_alloc_refused got=%0h/%0h exp=0/0", full, alloc_tag); end
    tick();
    alloc_valid = 1'b0;
    total++; if (full !== 1'b1 || alloc_tag !== 3'd1) begin bad++; $display("FAIL count7_refill got=%0h/%0h exp=1/1", full, alloc_tag); end
  endtask

  task automatic test_flush();
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      alloc_valid = 1'b1; alloc_opcode = 4'b0101; alloc_dest = 4'(i); tick();
    end
    alloc_valid = 1'b0;
    total++; if (alloc_tag !== 3'd4 || empty !== 1'b0) begin bad++; $display("FAIL preflush got=%0h/%0h exp=4/0", alloc_tag, empty); end
    cdb_valid = 1'b1; cdb_tag = 3'd0; cdb_value = 8'h3C; tick();
    cdb_tag = 3'd1; flush = 1'b1; alloc_valid = 1'b1;
    tick();
    flush = 1'b0; cdb_valid = 1'b0; alloc_valid = 1'b0; rd_tag = 3'd1; #1;
    total++; if ({commit_valid, empty, full, alloc_tag} !== {1'b0, 1'b1, 1'b0, 3'd0}) begin
      bad++; $display("FAIL flush got=%0h/%0h/%0h/%0h exp=0/1/0/0", commit_valid, empty, full, alloc_tag); end
    total++; if (rd_ready !== 1'b0 || rd_value !== 8'h00) begin bad++; $display("FAIL flush_lookup got=%0h/%0h exp=0/0", rd_ready, rd_value); end
  endtask

  task automatic test_async_reset();
    alloc_valid = 1'b1; alloc_opcode = 4'b0010; alloc_dest = 4'd7; tick();
    alloc_valid = 1'b0;
    cdb_valid = 1'b1; cdb_tag = 3'd0; cdb_value = 8'h99; tick();
    cdb_valid = 1'b0;
    tick();
    total++; if (commit_valid !== 1'b1 || commit_value !== 8'h99) begin bad++; $display("FAIL pre_async got=%0h/%0h exp=1/99", commit_valid, commit_value); end
    #2; rst = 1'b1; #1;
    total++; if (commit_valid !== 1'b0 || commit_value !== 8'h00 || empty !== 1'b1) begin
      bad++; $display("FAIL async_reset got=%0h/%0h/%0h exp=0/0/1", commit_valid, commit_value, empty); end
    tick();
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_writeback_order();
    test_bypass();
    test_full_wrap();
    test_full_commit_alloc();
    test_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- 8-entry circular reorder buffer sitting directly downstream of dispatch/issue and upstream of the register file in the Tomasulo core.
- Dispatch allocates one entry per cycle in program order; the allocated entry index is the rename tag for the destination register.
- Functional units return results on the common data bus (CDB), tagged by entry index.
- Entries retire strictly in order from the head, one per cycle, presenting dest/value to the register file.

Parameters:
- DEPTH, 8, number of entries (power of two)
- TAG_W, 3, log2(DEPTH), width of the tag and of the head/tail pointers
- DATA_W, 8, result width (1-byte datapath)

Ports:
- clk  input  1  clock, rising-edge
- rst  input  1  asynchronous, active-high reset
- flush  input  1  synchronous clear of all entries
- alloc_valid  input  1  dispatch requests an entry this cycle
- alloc_opcode  input  4  opcode of the dispatched instruction (0000 sub … 0101 load)
- alloc_dest  input  4  architectural destination register
- alloc_ready  output  1  entry available; equals !full
- alloc_tag  output  TAG_W  index the next allocation receives (= tail)
- cdb_valid  input  1  result broadcast
- cdb_tag  input  TAG_W  entry the result belongs to
- cdb_value  input  DATA_W  result value
- rd_tag  input  TAG_W  operand lookup tag from dispatch
- rd_ready  output  1  looked-up entry has its result (combinational)
- rd_value  output  DATA_W  looked-up result (combinational)
- commit_valid  output  1  one-cycle pulse: an entry retired
- commit_opcode  output  4  opcode of the retired entry
- commit_dest  output  4  destination register of the retired entry
- commit_value  output  DATA_W  result of the retired entry
- commit_tag  output  TAG_W  index of the retired entry, so the rename table can clear a matching mapping
- full  output  1  count == DEPTH
- empty  output  1  count == 0

Behaviour:
- State per entry: busy, done, opcode[3:0], dest[3:0], value[DATA_W-1:0]. Pointers head and tail are TAG_W wide and wrap 7→0. Count is TAG_W+1 wide.
- Reset (async, rst=1): all busy/done=0; head=tail=0; count=0; commit_valid=0; commit_opcode/dest/value/tag=0; full=0; empty=1; alloc_ready=1; alloc_tag=0.
- Allocate: at a posedge with alloc_valid && alloc_ready, entry[tail] is loaded with busy=1, done=0, opcode, dest, value=0, and tail increments.
  - alloc_ready is derived from the pre-edge count. When full, allocation is refused even if a commit occurs in the same cycle.
  - alloc_valid while full is ignored; no state change.
- Writeback: at a posedge with cdb_valid, if entry[cdb_tag] has busy=1 and done=0, set done=1 and value=cdb_value. Otherwise the broadcast is ignored.
- Commit: at a posedge where entry[head] has busy=1 and done=1 (pre-edge state):
  - commit_valid<=1 and commit_* <= that entry's fields plus head.
  - entry busy/done<=0; head increments.
  - Otherwise commit_valid<=0, and the other commit_* outputs hold their last values.
  - Latency: a CDB write at edge N makes the earliest commit_valid visible after edge N+1.
  - No backpressure; the register file must accept every commit.
  - Stores (0100) commit identically; consumers ignore dest for stores.
- Count: next = count + (alloc accepted) − (commit). Simultaneous alloc and commit when not full leaves count unchanged.
- Same-entry writeback and alloc cannot collide, because alloc targets a non-busy entry and writeback requires busy=1.
- Lookup: rd_ready = (busy[rd_tag] && done[rd_tag]) || (cdb_valid && cdb_tag==rd_tag && busy[rd_tag]). rd_value comes from the CDB when the bypass condition holds, else from entry[rd_tag].value. For a non-busy entry, rd_ready=0 and rd_value=0.
- Flush: at a posedge with flush=1 (rst=0):
  - clears all busy/done, head=tail=0, count=0, commit_valid=0.
  - Same-cycle alloc, writeback and commit are discarded.
- Reset asserted mid-operation clears state immediately, regardless of clk.

Test Plan:
- Reset, then 3 allocs (opcode 0001, dest 2/3/4) -> alloc_tag 0,1,2; count=3; empty=0; no commit_valid.
- CDB tag 1 value 0x11, then tag 0 value 0x22 -> commit of tag0 (dest 2, 0x22) on the cycle after the tag-0 write, tag1 (dest 3, 0x11) the next cycle; strict order.
- Fill 8 entries -> full=1, alloc_ready=0. A 9th alloc is dropped. Complete and commit all -> head wraps 7→0; then alloc -> alloc_tag=0.
- Full buffer, head done, alloc_valid=1 in the commit cycle -> commit occurs, alloc is refused, count=7 afterward.
- rd_tag=2 with cdb_valid, cdb_tag=2, value 0x5A in the same cycle -> rd_ready=1, rd_value=0x5A combinationally. CDB to a non-busy tag 6 -> no state change.
- Alloc 4 entries, flush -> empty=1, tail=0. Assert rst asynchronously mid-commit -> commit_valid drops to 0 without a clock edge.
